handshake_coeff_arbiter: RTL and testbench

- Shares one fixed-point coefficient ROM among NUM_REQ handshake requesters in the tanh soft-clip datapath.
- Each requester presents a coefficient index on an elastic channel.
- A round-robin arbiter grants one requester per cycle, and the ROM word is registered into a one-entry output slot tagged with the requester ID.
- It replaces per-site constant units when many operators need coefficients from the same table.

---
 rtl/handshake_coeff_pkg.sv | 26 ++
 rtl/handshake_coeff_arbiter_if.sv | 27 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/handshake_coeff_arbiter.sv | 84 ++++++++
 tb/tb_handshake_coeff_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/handshake_coeff_pkg.sv
// Shared constants for the coefficient arbiter: the fixed-point coefficient table
// and a constant clog2 helper.
package handshake_coeff_pkg;

    localparam int unsigned DATA_WIDTH = 18;
    localparam int unsigned IDX_WIDTH  = 3;
    localparam int unsigned ROM_DEPTH  = 1 << IDX_WIDTH;

    typedef logic [DATA_WIDTH-1:0] coeff_t;

    // Signed 18-bit fixed point; idx 1 and idx 6 are -698 and +698.
    localparam coeff_t COEFF_ROM [ROM_DEPTH] = '{
        18'h00000, 18'h3FD46, 18'h00400, 18'h3FC00,
        18'h0FFFF, 18'h30001, 18'h002BA, 18'h1FFFF
    };

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/handshake_coeff_arbiter_if.sv
// Requester channels plus the registered output slot of the coefficient arbiter.
interface handshake_coeff_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = handshake_coeff_pkg::DATA_WIDTH,
    parameter int unsigned IDX_WIDTH  = handshake_coeff_pkg::IDX_WIDTH,
    parameter int unsigned TAG_WIDTH  = 2
);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*IDX_WIDTH-1:0] req_idx;
    logic [DATA_WIDTH-1:0]        outs;
    logic [TAG_WIDTH-1:0]         outs_tag;
    logic                         outs_valid;
    logic                         outs_ready;

    modport slave (
        input  req_valid, req_idx, outs_ready,
        output req_ready, outs, outs_tag, outs_valid
    );

    modport master (
        output req_valid, req_idx, outs_ready,
        input  req_ready, outs, outs_tag, outs_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the
// pointer, with wrap-around. The pointer register lives in the parent.
module rr_arbiter
    import handshake_coeff_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] pointer,
    input  logic         enable,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any_grant
);

    function automatic logic [W-1:0] wrap(input logic [W-1:0] p, input int unsigned k);
        return W'((32'(p) + k) % N);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        if (enable) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (!any_grant && req[wrap(pointer, k)]) begin
                    grant[wrap(pointer, k)] = 1'b1;
                    grant_idx               = wrap(pointer, k);
                    any_grant               = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/handshake_coeff_arbiter.sv
// Shares one coefficient ROM among NUM_REQ elastic requesters; the looked-up
// word lands in a one-entry output slot tagged with the winning requester.
module handshake_coeff_arbiter
    import handshake_coeff_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned IDX_WIDTH  = 3,
    parameter int unsigned TAG_WIDTH  = 2
) (
    input logic                        clk,
    input logic                        rst,
    handshake_coeff_arbiter_if.slave   bus
);

    logic                  free;
    logic                  arb_enable;
    logic [NUM_REQ-1:0]    grant;
    logic [TAG_WIDTH-1:0]  grant_idx;
    logic                  any_grant;
    logic [IDX_WIDTH-1:0]  sel_idx;
    logic [DATA_WIDTH-1:0] coeff;

    logic [DATA_WIDTH-1:0] outs_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  valid_q;
    logic [TAG_WIDTH-1:0]  ptr_q;
    logic [TAG_WIDTH-1:0]  ptr_d;

    assign free = !valid_q | bus.outs_ready;
    // Gating with rst keeps req_ready low while reset is held.
    assign arb_enable = free & rst;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .pointer   (ptr_q),
        .enable    (arb_enable),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        sel_idx = bus.req_idx[grant_idx*IDX_WIDTH +: IDX_WIDTH];
        coeff   = DATA_WIDTH'(COEFF_ROM[sel_idx]);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_grant) begin
            if (grant_idx == TAG_WIDTH'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + TAG_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outs_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (any_grant) begin
                outs_q  <= coeff;
                tag_q   <= grant_idx;
                valid_q <= 1'b1;
            end else if (bus.outs_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.outs       = outs_q;
    assign bus.outs_tag   = tag_q;
    assign bus.outs_valid = valid_q;

endmodule

// File: tb/tb_handshake_coeff_arbiter.sv
// Directed bench for handshake_coeff_arbiter: reset, single grant, round-robin,
// backpressure, drain, asynchronous reset and upper ROM entries.
module tb_handshake_coeff_arbiter;

    localparam int unsigned DATA_WIDTH = 18;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned IDX_WIDTH  = 3;
    localparam int unsigned TAG_WIDTH  = 2;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    handshake_coeff_arbiter_if #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) bus ();

    handshake_coeff_arbiter #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REQ    (NUM_REQ),
        .IDX_WIDTH  (IDX_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rr_coeff [5] = '{32'h00000, 32'h3FD46, 32'h00400, 32'h3FC00, 32'h00000};
    logic [31:0] hi_coeff [4] = '{32'h0FFFF, 32'h30001, 32'h002BA, 32'h1FFFF};

    initial begin
        rst            = 1'b0;
        bus.req_valid  = 4'hF;
        bus.req_idx    = {3'd3, 3'd2, 3'd1, 3'd0};
        bus.outs_ready = 1'b0;
        repeat (2) tick();
        check("rst_valid", 32'(bus.outs_valid), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_outs", 32'(bus.outs), 32'h0);
        check("rst_tag", 32'(bus.outs_tag), 32'd0);

        rst           = 1'b1;
        bus.req_valid = 4'h0;
        repeat (2) tick();
        check("idle_valid", 32'(bus.outs_valid), 32'd0);
        check("idle_ready", 32'(bus.req_ready), 32'h0);

        // Single requester 2 asking for idx 1.
        bus.req_valid  = 4'b0100;
        bus.req_idx    = {3'd0, 3'd1, 3'd0, 3'd0};
        bus.outs_ready = 1'b1;
        #1;
        check("single_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'h0;
        check("single_outs", 32'(bus.outs), 32'h3FD46);
        check("single_tag", 32'(bus.outs_tag), 32'd2);
        check("single_valid", 32'(bus.outs_valid), 32'd1);

        // Asynchronous reset pulse clears the full slot and the pointer.
        #2;
        rst = 1'b0;
        #1;
        check("pulse_valid", 32'(bus.outs_valid), 32'd0);
        rst = 1'b1;

        // All four contending, each asking for its own index.
        bus.req_idx   = {3'd3, 3'd2, 3'd1, 3'd0};
        bus.req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
            tick();
            check("rr_tag", 32'(bus.outs_tag), 32'(k % 4));
            check("rr_outs", 32'(bus.outs), rr_coeff[k]);
            check("rr_valid", 32'(bus.outs_valid), 32'd1);
        end

        // Load tag 1, then stall with requesters 0 and 3 waiting.
        bus.req_valid = 4'b0010;
        #1;
        check("bp_load_ready", 32'(bus.req_ready), 32'h2);
        tick();
        check("bp_load_tag", 32'(bus.outs_tag), 32'd1);
        bus.outs_ready = 1'b0;
        bus.req_valid  = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready", 32'(bus.req_ready), 32'h0);
            tick();
            check("bp_outs", 32'(bus.outs), 32'h3FD46);
            check("bp_tag", 32'(bus.outs_tag), 32'd1);
            check("bp_valid", 32'(bus.outs_valid), 32'd1);
        end
        bus.outs_ready = 1'b1;
        #1;
        check("bp_rel_ready3", 32'(bus.req_ready), 32'h8);
        tick();
        check("bp_rel_tag3", 32'(bus.outs_tag), 32'd3);
        check("bp_rel_outs3", 32'(bus.outs), 32'h3FC00);
        bus.req_valid = 4'b0001;
        #1;
        check("bp_rel_ready0", 32'(bus.req_ready), 32'h1);
        tick();
        check("bp_rel_tag0", 32'(bus.outs_tag), 32'd0);
        check("bp_rel_outs0", 32'(bus.outs), 32'h00000);

        // Refill with requester 2, then drain with nobody waiting.
        bus.req_valid = 4'b0100;
        #1;
        check("drain_ready2", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'h0;
        check("drain_pre_outs", 32'(bus.outs), 32'h00400);
        tick();
        check("drain_valid", 32'(bus.outs_valid), 32'd0);
        check("drain_outs", 32'(bus.outs), 32'h00400);
        check("drain_tag", 32'(bus.outs_tag), 32'd2);
        bus.req_valid = 4'hF;
        #1;
        check("drain_ptr_ready", 32'(bus.req_ready), 32'h8);
        tick();
        check("drain_ptr_tag", 32'(bus.outs_tag), 32'd3);
        check("drain_ptr_valid", 32'(bus.outs_valid), 32'd1);

        // Reset mid-cycle with tag 3 in the slot.
        bus.outs_ready = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.outs_valid), 32'd0);
        check("mid_rst_tag", 32'(bus.outs_tag), 32'd0);
        check("mid_rst_outs", 32'(bus.outs), 32'h0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        #2;
        rst            = 1'b1;
        bus.req_valid  = 4'b1010;
        bus.req_idx    = {3'd3, 3'd2, 3'd1, 3'd0};
        bus.outs_ready = 1'b1;
        #1;
        check("post_rst_ready1", 32'(bus.req_ready), 32'h2);
        tick();
        check("post_rst_tag1", 32'(bus.outs_tag), 32'd1);
        check("post_rst_outs1", 32'(bus.outs), 32'h3FD46);
        bus.req_valid = 4'b1000;
        #1;
        check("post_rst_ready3", 32'(bus.req_ready), 32'h8);
        tick();
        check("post_rst_tag3", 32'(bus.outs_tag), 32'd3);
        check("post_rst_outs3", 32'(bus.outs), 32'h3FC00);

        // Upper table entries through requester 0, back to back.
        bus.req_valid = 4'b0001;
        for (int i = 4; i < 8; i++) begin
            bus.req_idx = 12'(i);
            #1;
            check("hi_ready", 32'(bus.req_ready), 32'h1);
            tick();
            check("hi_outs", 32'(bus.outs), hi_coeff[i-4]);
            check("hi_tag", 32'(bus.outs_tag), 32'd0);
        end
        bus.req_valid = 4'h0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
